// File: rtl/data_types_pkg.sv
// Shared types and constants for the convolution sequencer slice.
package data_types_pkg;

    // Pass sequencing states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_CONV,
        ST_WAIT_OUT,
        ST_VALID,
        ST_DONE
    } conv_seq_state_t;

    localparam int KERNEL_ROWS    = 3;
    localparam int KERNEL_COLS    = 3;
    localparam int KERNEL_TAPS    = KERNEL_ROWS * KERNEL_COLS;
    localparam int ADDR_WIDTH_RAM = 8;
    localparam int W_BASE_RAM     = 0;
    localparam int IMG_BASE_RAM   = 16;

    // Counter width for a range of n values, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Kernel-window walker: kr/kc tap counters, orow/ocol window counters and the
// image address adder. Counters always point at the tap to be issued next.
module window_addr_gen
    import data_types_pkg::*;
#(
    parameter int N_ROWS     = KERNEL_ROWS,
    parameter int N_COLUMNS  = KERNEL_COLS,
    parameter int IMG_ROWS   = 8,
    parameter int IMG_COLS   = 8,
    parameter int ADDR_WIDTH = ADDR_WIDTH_RAM,
    parameter int IMG_BASE   = IMG_BASE_RAM
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          step,
    input  logic                          next_win,
    output logic [ADDR_WIDTH-1:0]         addr,
    output logic                          tap_first,
    output logic                          tap_last,
    output logic                          win_last,
    output logic [cnt_w(IMG_ROWS)-1:0]    orow,
    output logic [cnt_w(IMG_COLS)-1:0]    ocol
);

    localparam int KR_W     = cnt_w(N_ROWS);
    localparam int KC_W     = cnt_w(N_COLUMNS);
    localparam int ROW_W    = cnt_w(IMG_ROWS);
    localparam int COL_W    = cnt_w(IMG_COLS);
    localparam int OROW_MAX = IMG_ROWS - N_ROWS;
    localparam int OCOL_MAX = IMG_COLS - N_COLUMNS;

    logic [KR_W-1:0] kr;
    logic [KC_W-1:0] kc;

    // Tap counters advance on step (kc inner, kr outer); window counters on next_win
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kr   <= '0;
            kc   <= '0;
            orow <= '0;
            ocol <= '0;
        end else if (clear) begin
            kr   <= '0;
            kc   <= '0;
            orow <= '0;
            ocol <= '0;
        end else begin
            if (step) begin
                if (kc == KC_W'(N_COLUMNS - 1)) begin
                    kc <= '0;
                    kr <= (kr == KR_W'(N_ROWS - 1)) ? '0 : kr + KR_W'(1);
                end else begin
                    kc <= kc + KC_W'(1);
                end
            end
            if (next_win) begin
                if (ocol == COL_W'(OCOL_MAX)) begin
                    ocol <= '0;
                    orow <= (orow == ROW_W'(OROW_MAX)) ? '0 : orow + ROW_W'(1);
                end else begin
                    ocol <= ocol + COL_W'(1);
                end
            end
        end
    end

    // Row-major image address of the pending tap, unsigned at full address width
    always_comb begin
        logic [ADDR_WIDTH-1:0] row_a;
        logic [ADDR_WIDTH-1:0] col_a;
        row_a = ADDR_WIDTH'(orow) + ADDR_WIDTH'(kr);
        col_a = ADDR_WIDTH'(ocol) + ADDR_WIDTH'(kc);
        addr  = ADDR_WIDTH'(IMG_BASE) + row_a * ADDR_WIDTH'(IMG_COLS) + col_a;
    end

    assign tap_first = (kr == '0) && (kc == '0);
    assign tap_last  = (kr == KR_W'(N_ROWS - 1)) && (kc == KC_W'(N_COLUMNS - 1));
    assign win_last  = (orow == ROW_W'(OROW_MAX)) && (ocol == COL_W'(OCOL_MAX));

endmodule

// File: rtl/conv_sequencer.sv
// Sequences one 2-D convolution pass: weight load, then every kernel window,
// with MAC strobes aligned to the RAM's one-cycle read latency and a
// valid/ready handshake per output position. All outputs are registered.
module conv_sequencer
    import data_types_pkg::*;
#(
    parameter int N_ROWS     = KERNEL_ROWS,
    parameter int N_COLUMNS  = KERNEL_COLS,
    parameter int IMG_ROWS   = 8,
    parameter int IMG_COLS   = 8,
    parameter int ADDR_WIDTH = ADDR_WIDTH_RAM,
    parameter int W_BASE     = W_BASE_RAM,
    parameter int IMG_BASE   = IMG_BASE_RAM
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    output logic [ADDR_WIDTH-1:0]                   ram_addr,
    output logic                                    ram_re,
    output logic                                    w_we,
    output logic [cnt_w(N_ROWS*N_COLUMNS)-1:0]      w_idx,
    output logic                                    mac_en,
    output logic                                    mac_clear,
    output logic                                    mac_last,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [cnt_w(IMG_ROWS)-1:0]              out_row,
    output logic [cnt_w(IMG_COLS)-1:0]              out_col,
    output logic                                    busy,
    output logic                                    done
);

    localparam int TAPS   = N_ROWS * N_COLUMNS;
    localparam int WIDX_W = cnt_w(TAPS);

    conv_seq_state_t             state;
    logic [WIDX_W-1:0]           widx;
    logic                        tap_first_p0;
    logic                        tap_last_p0;
    logic                        win_last_p0;

    logic                        gen_clear;
    logic                        gen_step;
    logic                        gen_next_win;
    logic [ADDR_WIDTH-1:0]       gen_addr;
    logic                        gen_first;
    logic                        gen_tap_last;
    logic                        gen_win_last;
    logic [cnt_w(IMG_ROWS)-1:0]  gen_orow;
    logic [cnt_w(IMG_COLS)-1:0]  gen_ocol;

    window_addr_gen #(
        .N_ROWS     (N_ROWS),
        .N_COLUMNS  (N_COLUMNS),
        .IMG_ROWS   (IMG_ROWS),
        .IMG_COLS   (IMG_COLS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .IMG_BASE   (IMG_BASE)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .clear     (gen_clear),
        .step      (gen_step),
        .next_win  (gen_next_win),
        .addr      (gen_addr),
        .tap_first (gen_first),
        .tap_last  (gen_tap_last),
        .win_last  (gen_win_last),
        .orow      (gen_orow),
        .ocol      (gen_ocol)
    );

    // Decide when an image tap is issued this edge; that is also when the walker steps
    always_comb begin
        gen_clear    = (state == ST_IDLE) && start;
        gen_next_win = (state == ST_WAIT_OUT);
        gen_step     = 1'b0;
        unique case (state)
            ST_LOAD_W: gen_step = (widx == WIDX_W'(TAPS - 1));
            ST_CONV:   gen_step = !tap_last_p0;
            ST_VALID:  gen_step = out_ready && !win_last_p0;
            default:   gen_step = 1'b0;
        endcase
    end

    // Pass FSM with registered outputs; strobes default low and are raised per state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            widx         <= '0;
            tap_first_p0 <= 1'b0;
            tap_last_p0  <= 1'b0;
            win_last_p0  <= 1'b0;
            ram_addr     <= '0;
            ram_re       <= 1'b0;
            w_we         <= 1'b0;
            w_idx        <= '0;
            mac_en       <= 1'b0;
            mac_clear    <= 1'b0;
            mac_last     <= 1'b0;
            out_valid    <= 1'b0;
            out_row      <= '0;
            out_col      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            ram_re    <= 1'b0;
            w_we      <= 1'b0;
            mac_en    <= 1'b0;
            mac_clear <= 1'b0;
            mac_last  <= 1'b0;
            done      <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_LOAD_W;
                        widx     <= '0;
                        ram_re   <= 1'b1;
                        ram_addr <= ADDR_WIDTH'(W_BASE);
                        busy     <= 1'b1;
                    end
                end
                // p0 -> p1: weight read on the bus becomes a register-file write
                ST_LOAD_W: begin
                    w_we  <= 1'b1;
                    w_idx <= widx;
                    if (widx == WIDX_W'(TAPS - 1)) begin
                        state <= ST_CONV;
                        widx  <= '0;
                    end else begin
                        widx     <= widx + WIDX_W'(1);
                        ram_re   <= 1'b1;
                        ram_addr <= ADDR_WIDTH'(W_BASE) + ADDR_WIDTH'(widx) + ADDR_WIDTH'(1);
                    end
                end
                // p0 -> p1: tap read on the bus becomes MAC strobes with the data
                ST_CONV: begin
                    mac_en    <= 1'b1;
                    mac_clear <= tap_first_p0;
                    mac_last  <= tap_last_p0;
                    if (tap_last_p0) begin
                        state <= ST_WAIT_OUT;
                    end
                end
                ST_WAIT_OUT: begin
                    state       <= ST_VALID;
                    out_valid   <= 1'b1;
                    out_row     <= gen_orow;
                    out_col     <= gen_ocol;
                    win_last_p0 <= gen_win_last;
                end
                ST_VALID: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (win_last_p0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_CONV;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (gen_step) begin
                ram_re       <= 1'b1;
                ram_addr     <= gen_addr;
                tap_first_p0 <= gen_first;
                tap_last_p0  <= gen_tap_last;
            end
        end
    end

endmodule

// File: tb/tb_conv_sequencer.sv
// Randomized bench for conv_sequencer against a pass-level reference model.
module tb_conv_sequencer;
    import data_types_pkg::*;

    localparam int KR = 3, KC = 3, IR = 8, IC = 8, AW = 8, WB = 0, IB = 16;
    localparam int T  = KR * KC;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] ram_addr;
    logic          ram_re;
    logic          w_we;
    logic [3:0]    w_idx;
    logic          mac_en;
    logic          mac_clear;
    logic          mac_last;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    out_row;
    logic [2:0]    out_col;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    conv_sequencer #(
        .N_ROWS(KR), .N_COLUMNS(KC), .IMG_ROWS(IR), .IMG_COLS(IC),
        .ADDR_WIDTH(AW), .W_BASE(WB), .IMG_BASE(IB)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .ram_addr(ram_addr), .ram_re(ram_re),
        .w_we(w_we), .w_idx(w_idx),
        .mac_en(mac_en), .mac_clear(mac_clear), .mac_last(mac_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_col(out_col),
        .busy(busy), .done(done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    typedef struct {
        int addr;
        bit is_tap;
        int widx;
        bit first;
        bit last;
    } rd_t;

    function automatic logic [31:0] all_outputs();
        return 32'({ram_addr, ram_re, w_we, w_idx, mac_en, mac_clear, mac_last,
                    out_valid, out_row, out_col, busy, done});
    endfunction

    // mode 0: always ready, 1: random ready, 2: 5-cycle stall at (0,1)
    task automatic run_pass(input int mode, input bit inject, input int abort_cyc,
                            output int done_cyc, output int act_hs, output int last_tap);
        rd_t  rdq[$];
        int   posq[$];
        rd_t  e;
        rd_t  prev;
        bit   prev_v = 0;
        int   rd_left;
        int   valid_in = -1;
        bit   exp_valid = 0;
        int   done_due = 1 << 30;
        int   stall_n = 0;
        bit   finished = 0;
        logic [3:0] exp_str;

        for (int w = 0; w < T; w++) rdq.push_back('{WB + w, 1'b0, w, 1'b0, 1'b0});
        for (int r = 0; r <= IR - KR; r++)
            for (int c = 0; c <= IC - KC; c++) begin
                posq.push_back(r * 256 + c);
                for (int a = 0; a < KR; a++)
                    for (int b = 0; b < KC; b++)
                        rdq.push_back('{IB + (r + a) * IC + (c + b), 1'b1, 0,
                                        (a == 0 && b == 0), (a == KR - 1 && b == KC - 1)});
            end

        done_cyc = -1;
        act_hs   = 0;
        last_tap = -1;
        @(posedge clk); #1;
        start = 1'b1;
        out_ready = 1'b1;
        rd_left = 2 * T;

        for (int cyc = 1; cyc < 5000; cyc++) begin
            @(posedge clk); #1;
            start = (inject && cyc == 15);

            exp_str = !prev_v ? 4'b0000 :
                      (prev.is_tap ? {1'b0, 1'b1, prev.first, prev.last} : 4'b1000);
            check("strobes", {w_we, mac_en, mac_clear, mac_last}, exp_str);
            if (prev_v && !prev.is_tap) check("w_idx", w_idx, prev.widx);

            if (valid_in > 0) begin
                valid_in--;
                if (valid_in == 0) begin
                    exp_valid = 1;
                    valid_in = -1;
                end
            end

            prev_v = 0;
            check("ram_re", ram_re, rd_left > 0);
            if (rd_left > 0) begin
                e = rdq.pop_front();
                check("ram_addr", ram_addr, e.addr);
                prev = e;
                prev_v = 1;
                if (ram_re && e.is_tap) last_tap = int'(ram_addr);
                rd_left--;
                if (rd_left == 0) valid_in = 2;
            end

            check("out_valid", out_valid, exp_valid);
            if (exp_valid) check("out_pos", int'(out_row) * 256 + int'(out_col), posq[0]);
            check("done", done, cyc == done_due);
            check("busy", busy, cyc <= done_due);
            if (done && done_cyc < 0) done_cyc = cyc;

            if (cyc == abort_cyc) begin
                finished = 1;
                break;
            end

            case (mode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (exp_valid && posq[0] == 1 && stall_n < 5) begin
                        out_ready = 1'b0;
                        stall_n++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase

            if (out_valid && out_ready) act_hs++;
            if (exp_valid && out_ready) begin
                void'(posq.pop_front());
                exp_valid = 0;
                if (posq.size() == 0) done_due = cyc + 1;
                else rd_left = T;
            end

            if (cyc >= done_due + 2) begin
                finished = 1;
                break;
            end
        end
        start = 1'b0;
        check("pass_terminated", finished, 1'b1);
    endtask

    int done_cyc, hs, last_tap;

    initial begin
        rst = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        #1;
        check("reset_outputs", all_outputs(), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("idle_outputs", all_outputs(), 0);

        // No backpressure, stray start mid-CONV
        run_pass(0, 1'b1, -1, done_cyc, hs, last_tap);
        check("pass_len", done_cyc, 406);
        check("handshakes", hs, 36);
        check("last_tap_addr", last_tap, 16 + 7 * 8 + 7);

        // Directed stall at (0,1)
        run_pass(2, 1'b0, -1, done_cyc, hs, last_tap);
        check("handshakes_stall", hs, 36);

        // Random backpressure, a few passes
        for (int p = 0; p < 3; p++) begin
            run_pass(1, 1'b0, -1, done_cyc, hs, last_tap);
            check("handshakes_rand", hs, 36);
        end

        // Reset mid-CONV, then a clean restart
        run_pass(0, 1'b0, 15, done_cyc, hs, last_tap);
        #2 rst = 1'b0;
        #1;
        check("midpass_reset", all_outputs(), 0);
        @(posedge clk); #1;
        check("reset_hold", all_outputs(), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("after_release", all_outputs(), 0);
        run_pass(0, 1'b0, -1, done_cyc, hs, last_tap);
        check("restart_len", done_cyc, 406);
        check("restart_handshakes", hs, 36);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
